// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART register file and the transmit/receive
// engines. Holds the transmit FSM state encoding, the bit positions inside the
// 3-bit uart_mode field, and the smallest legal clocks-per-bit value.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int MODE_W       = 3;
  localparam int MODE_PAR_EN  = 0;  // 1 = parity bit present
  localparam int MODE_PAR_ODD = 1;  // 1 = odd parity, 0 = even parity
  localparam int MODE_STOP2   = 2;  // 1 = two stop bits

  localparam int MIN_RATE = 2;

  // Parity bit on the line: even parity is the XOR of the data bits,
  // odd parity is its inverse.
  function automatic logic parity_bit(input logic data_xor, input logic odd);
    return data_xor ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Loadable down-counter that times one bit period. Loading with rate-1 makes
// tick fire after exactly 'rate' clocks. The count holds at zero rather than
// wrapping, so tick stays high until the next load.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load load_val on the next edge
//   load_val in   WIDTH  value to load
//   tick     out  count is zero
// -----------------------------------------------------------------------------
module uart_baud_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             tick
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tick = (r_count == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// Serialises bytes from a valid/ready port into UART frames
// (start, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits).
// Frame format and clocks-per-bit are captured at accept, so register-file
// updates mid-frame only affect the next frame.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   uart_enable   transmit enable from the register file
//   uart_mode     [2:0] parity enable / odd parity / two stop bits
//   uart_rate     [RATE_WIDTH-1:0] clocks per bit
//   tx_valid      byte offered
//   tx_data       [DATA_WIDTH-1:0] byte to send
//   tx_ready      engine can accept a byte (combinational)
//   tx            serial line, idles high (registered)
//   uart_busy     frame in progress (registered)
//   uart_error    illegal request seen last cycle (registered)
//   update_ok     register file may commit the baud shadow (combinational)
// -----------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATE_WIDTH = 16,
  parameter int MIN_RATE   = uart_pkg::MIN_RATE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  uart_enable,
  input  logic [MODE_W-1:0]     uart_mode,
  input  logic [RATE_WIDTH-1:0] uart_rate,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  uart_busy,
  output logic                  uart_error,
  output logic                  update_ok
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_e             r_state;
  tx_state_e             w_state_nxt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [RATE_WIDTH-1:0] r_rate;
  logic                  r_par_en;
  logic                  r_stop2;
  logic                  r_parity;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic                  r_stop2_done;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_error;

  logic                  w_rate_ok;
  logic                  w_accept;
  logic                  w_tick;
  logic                  w_load;
  logic [RATE_WIDTH-1:0] w_load_val;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;
  logic                  w_shift;
  logic                  w_bit_clr;
  logic                  w_bit_inc;
  logic                  w_stop2_set;

  assign w_rate_ok  = (uart_rate >= RATE_WIDTH'(MIN_RATE));
  assign tx_ready   = (r_state == IDLE) && uart_enable && w_rate_ok;
  assign w_accept   = tx_valid && tx_ready;
  assign update_ok  = (r_state == IDLE) && !tx_valid;

  assign tx         = r_tx;
  assign uart_busy  = r_busy;
  assign uart_error = r_error;

  uart_baud_cnt #(
    .WIDTH(RATE_WIDTH)
  ) u_baud_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .load_val(w_load_val),
    .tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // tx is registered from the value of the bit being entered, so the line
  // changes on the same edge as the state and the start edge appears one
  // cycle after accept.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = r_rate - 1'b1;
    w_tx_nxt    = r_tx;
    w_busy_nxt  = r_busy;
    w_shift     = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    w_stop2_set = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = START;
          w_load      = 1'b1;
          w_load_val  = uart_rate - 1'b1;  // r_rate not yet captured
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_state_nxt = DATA;
          w_load      = 1'b1;
          w_tx_nxt    = r_shift[0];
          w_shift     = 1'b1;
          w_bit_clr   = 1'b1;
        end
      end
      DATA: begin
        if (w_tick) begin
          w_load = 1'b1;
          if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            if (r_par_en) begin
              w_state_nxt = PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_tx_nxt  = r_shift[0];
            w_shift   = 1'b1;
            w_bit_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_tick) begin
          w_state_nxt = STOP;
          w_load      = 1'b1;
          w_tx_nxt    = 1'b1;
        end
      end
      STOP: begin
        if (w_tick) begin
          // Second stop bit reuses the STOP state for one more period.
          if (r_stop2 && !r_stop2_done) begin
            w_load      = 1'b1;
            w_stop2_set = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_error      <= 1'b0;
      r_bit_cnt    <= '0;
      r_stop2_done <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_busy  <= w_busy_nxt;
      // A request that cannot be accepted while idle; tx_valid stays pending.
      r_error <= tx_valid && (r_state == IDLE) && !(uart_enable && w_rate_ok);
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (w_accept) begin
        r_stop2_done <= 1'b0;
      end else if (w_stop2_set) begin
        r_stop2_done <= 1'b1;
      end
    end
  end

  // Frame payload: only meaningful between accept and the end of STOP.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shift  <= tx_data;
      r_rate   <= uart_rate;
      r_par_en <= uart_mode[MODE_PAR_EN];
      r_stop2  <= uart_mode[MODE_STOP2];
      r_parity <= parity_bit(^tx_data, uart_mode[MODE_PAR_ODD]);
    end else if (w_shift) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Cycle-level bench. The reference model expands each accepted byte into the
// full expected line waveform (one entry per clock) held in a queue; the line,
// busy, ready, update_ok and error outputs are compared every cycle.
// Directed scenarios additionally measure busy-run lengths and start spacing.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int DW = 8;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uart_enable = 1'b0;
  logic [2:0]    uart_mode = 3'b000;
  logic [RW-1:0] uart_rate = '0;
  logic          tx_valid = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_ready, tx, uart_busy, uart_error, update_ok;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(
    .DATA_WIDTH(DW),
    .RATE_WIDTH(RW),
    .MIN_RATE  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_enable(uart_enable),
    .uart_mode  (uart_mode),
    .uart_rate  (uart_rate),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .uart_busy  (uart_busy),
    .uart_error (uart_error),
    .update_ok  (update_ok)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic m_q[$];      // expected tx level for each remaining frame clock
  logic m_err = 1'b0;
  bit   m_acc = 1'b0;

  // Observations for directed measurements
  int  cyc = 0;
  bit  prev_busy = 1'b0;
  int  cur_len = 0;
  int  lens[$];
  int  rises[$];

  function automatic int last_of(input int q[$], input int back);
    if (q.size() <= back) return -1;
    return q[q.size() - 1 - back];
  endfunction

  task automatic push_frame(input logic [7:0] d, input logic [2:0] m, input int r);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (m[0]) bits.push_back((^d) ^ m[1]);
    bits.push_back(1'b1);
    if (m[2]) bits.push_back(1'b1);
    foreach (bits[i]) repeat (r) m_q.push_back(bits[i]);
  endtask

  // Called at a falling edge with inputs already driven for this cycle.
  task automatic step();
    logic idle, ok;
    #1;
    idle = (m_q.size() == 0);
    ok   = uart_enable && (uart_rate >= 2);
    chk("tx",        tx,         idle ? 1'b1 : m_q[0]);
    chk("busy",      uart_busy,  !idle);
    chk("error",     uart_error, m_err);
    chk("ready",     tx_ready,   idle && ok);
    chk("update_ok", update_ok,  idle && !tx_valid);
    if (uart_busy && !prev_busy) rises.push_back(cyc);
    if (uart_busy) cur_len++;
    else if (prev_busy) begin
      lens.push_back(cur_len);
      cur_len = 0;
    end
    prev_busy = uart_busy;
    m_acc = idle && tx_valid && ok;
    m_err = tx_valid && idle && !ok;
    if (!idle) void'(m_q.pop_front());
    if (m_acc) push_frame(tx_data, uart_mode, int'(uart_rate));
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] m, input logic [RW-1:0] r,
                      input bit hold);
    int n = 0;
    tx_data = d; uart_mode = m; uart_rate = r; uart_enable = 1'b1; tx_valid = 1'b1;
    m_acc = 1'b0;
    while (!m_acc && n < 300) begin
      step();
      n++;
    end
    chk("accept", m_acc, 1'b1);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    chk("idle_timeout", (n < 2000), 1'b1);
    step();
  endtask

  initial begin
    @(negedge clk);
    // Reset state
    step();
    step();
    rst_n = 1'b1;
    step();

    // 8N1, rate 4, 0xA5
    send(8'hA5, 3'b000, 16'd4, 1'b0);
    wait_idle();
    chk("len_8N1", last_of(lens, 0), 40);

    // Parity and stop variants
    send(8'hA5, 3'b001, 16'd4, 1'b0);
    wait_idle();
    chk("len_8E1", last_of(lens, 0), 44);
    send(8'hA5, 3'b011, 16'd4, 1'b0);
    wait_idle();
    chk("len_8O1", last_of(lens, 0), 44);
    send(8'hA5, 3'b101, 16'd4, 1'b0);
    wait_idle();
    chk("len_8E2", last_of(lens, 0), 48);

    // Error path: disabled, then rate 1, then legal
    uart_enable = 1'b0; uart_rate = 16'd4; tx_valid = 1'b1; tx_data = 8'h5A;
    repeat (3) step();
    uart_enable = 1'b1; uart_rate = 16'd1;
    repeat (3) step();
    uart_rate = 16'd0;
    repeat (2) step();
    send(8'h5A, 3'b000, 16'd4, 1'b0);
    wait_idle();
    chk("len_after_err", last_of(lens, 0), 40);

    // Mid-frame config change with tx_valid held
    send(8'hA5, 3'b000, 16'd4, 1'b1);
    repeat (4) step();
    send(8'h3C, 3'b001, 16'd8, 1'b0);
    wait_idle();
    chk("len_cfg_old", last_of(lens, 1), 40);
    chk("len_cfg_new", last_of(lens, 0), 88);

    // Back-to-back 0x00 then 0xFF
    send(8'h00, 3'b000, 16'd4, 1'b1);
    send(8'hFF, 3'b000, 16'd4, 1'b0);
    wait_idle();
    chk("b2b_gap", last_of(rises, 0) - last_of(rises, 1), 41);

    // Reset in the 10th frame cycle
    send(8'hA5, 3'b000, 16'd4, 1'b0);
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", uart_busy, 1'b0);
    m_q.delete();
    m_err = 1'b0;
    prev_busy = 1'b0;
    cur_len = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", tx_ready, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        tx_valid    = ($urandom_range(0, 2) != 0);
        uart_enable = ($urandom_range(0, 7) != 0);
        uart_rate   = RW'($urandom_range(0, 5));
        uart_mode   = 3'($urandom);
        tx_data     = 8'($urandom);
      end
      step();
    end
    tx_valid = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
